serial_adder: RTL and testbench

//  Bit-serial add/subtract unit with parametrised operand width.
//  - Processes one bit per clock, LSB first, using a single full-adder cell.
//  - Start/busy/done handshake with registered result, carry-out and signed overflow.
//  - Successor to the combinational half-adder: it trades latency for area in narrow datapaths.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder_cell.sv | 50 +++++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial add/subtract unit.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half adders and an OR gate.
// This cell is the only arithmetic in the serial adder.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  // sum and carry of two bits
  always_comb begin
    s = x ^ y;
    c = x & y;
  end

endmodule

module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .x (s1),
    .y (ci),
    .s (s),
    .c (c2)
  );

  // at most one half adder can generate a carry, so OR merges them
  always_comb begin
    co = c1 | c2;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first.
// Subtraction is a + ~b + 1, so the operand is inverted at load and the
// carry flop is preset to 1. The result only becomes visible on the
// RUN->DONE edge; partial sums live in acc_q until then.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one operand bit pair consumed per edge, WIDTH edges total
// DONE  | one-cycle result-valid pulse; start here chains a new op
// (3)   | unused encoding, falls back to IDLE

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   acc_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               accept;
  logic               last_bit;
  logic               fa_s;
  logic               fa_co;

  // start is only honoured outside RUN, which gives back-to-back from DONE
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  full_adder_cell u_fa (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from the state register
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // operand shift registers, carry flop, bit counter and partial-sum shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      opa_q   <= a;
      opb_q   <= b ^ {WIDTH{sub}};
      acc_q   <= '0;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      opa_q   <= opa_q >> 1;
      opb_q   <= opb_q >> 1;
      acc_q   <= {fa_s, acc_q[WIDTH-1:1]};
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CNT_ONE;
    end
  end

  // result and flags, updated only when the final bit is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_bit) begin
      sum_q  <= {fa_s, acc_q[WIDTH-1:1]};
      cout_q <= fa_co;
      ovf_q  <= carry_q ^ fa_co;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // drive a request before the next edge, release start after it
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vcin, input logic vsub, input string tag);
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
  endtask

  // count edges until done, bounded; a timeout shows up as latency 0
  task automatic wait_done(input int exp_lat, input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic check_result(input logic [W-1:0] es, input logic ec, input logic eo,
                              input string tag);
    check({tag, " sum"},  32'(sum),  32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"},  32'(ovf),  32'(eo));
  endtask

  initial begin
    int  saw_done;
    logic [W-1:0] held;

    //          a      b      cin   sub   sum    cout  ovf
    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[6]  = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_result(8'h00, 1'b0, 1'b0, "reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // table-driven single operations
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, tag);
      wait_done(W, tag);
      check_result(vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, tag);
      @(posedge clk);
      #1;
      check({tag, " done one cycle"}, 32'(done), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
    end

    // mid-cycle reset clears registered outputs without a clock edge
    start_op(8'hFF, 8'h01, 1'b1, 1'b0, "pre-rst");
    wait_done(W, "pre-rst");
    check_result(8'h01, 1'b1, 1'b0, "pre-rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_result(8'h00, 1'b0, 1'b0, "async rst");
    check("async rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start and operand changes during RUN are ignored
    start_op(8'h11, 8'h22, 1'b0, 1'b0, "ign");
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign still busy", 32'(busy), 32'd1);
    wait_done(W - 3, "ign");
    check_result(8'h33, 1'b0, 1'b0, "ign");

    // start held during DONE chains a new op; old result held until it finishes
    held = sum;
    @(negedge clk);
    a = 8'h40; b = 8'h40; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b sum held", 32'(sum), 32'(held));
    wait_done(W - 3, "b2b");
    check_result(8'h80, 1'b0, 1'b1, "b2b");

    // reset in the middle of RUN aborts with no done pulse
    @(posedge clk);
    start_op(8'h55, 8'h22, 1'b0, 1'b0, "abort");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check_result(8'h00, 1'b0, 1'b0, "abort");
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done++;
    end
    check("abort no done", 32'(saw_done), 32'd0);

    start_op(8'h01, 8'h01, 1'b0, 1'b0, "fresh");
    wait_done(W, "fresh");
    check_result(8'h02, 1'b0, 1'b0, "fresh");

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
